wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
- Wishbone bus master that turns single-cycle host commands into Wishbone classic cycles toward slave peripherals.
- Slaves on this bus register their ack one cycle after stb&cyc, hold it while stb stays high, and drop it one cycle after stb falls. This master paces each transfer to that handshake.
- Supports single writes and incrementing-address read bursts, detects bus timeouts, and latches slave interrupts for the host.

Parameters:
- TIMEOUT, 256, cycles allowed per wait phase (ack-high wait, ack-low wait) before abort; must be >=2.
- COUNT_WIDTH, 8, width of the burst word count.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- cmd_en  in  1  command strobe, sampled only when cmd_busy=0
- cmd_wr  in  1  1=write, 0=read
- cmd_adr  in  32  start word address
- cmd_dat  in  32  write data
- cmd_count  in  COUNT_WIDTH  read word count; ignored for writes (always 1)
- cmd_busy  out  1  command in progress
- cmd_done  out  1  one-cycle pulse, command finished (success or error)
- cmd_err  out  1  one-cycle pulse with cmd_done on timeout or zero count
- rsp_valid  out  1  one-cycle pulse per completed word
- rsp_dat  out  32  read data, valid with rsp_valid; 0 for writes
- int_pending  out  1  sticky interrupt flag
- int_clr  in  1  clears int_pending
- wbm_we_o  out  1  Wishbone write enable
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_sel_o  out  4  byte selects, always 4'hF while stb is high
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_int_i  in  1  slave interrupt

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Reset mid-cycle drops cyc/stb on the next edge; no done pulse is issued.
- States: IDLE, REQ, RELEASE, FINISH. All outputs are registered.
- IDLE:
  - cmd_busy=0.
  - cmd_en=1 latches wr, adr, dat and count (count forced to 1 when wr=1), then goes to REQ.
  - Read with cmd_count=0: no bus activity; next cycle cmd_done=1, cmd_err=1; stay IDLE.
- REQ:
  - cyc=1, stb=1, we=wr, adr, dat_o=dat (0 for reads), sel=4'hF. Timer cleared on entry.
  - On ack_i=1: stb←0 (cyc stays 1), rsp_valid←1, rsp_dat←dat_i for reads or 0 for writes; decrement remaining; go to RELEASE.
- RELEASE:
  - stb=0, cyc=1. Wait for ack_i=0; the timer restarts on entry.
  - When ack_i=0 and remaining>0: adr←adr+1, go to REQ (stb high next cycle).
  - When ack_i=0 and remaining=0: go to FINISH.
- FINISH: cyc←0, cmd_done=1 for one cycle, go to IDLE. cmd_busy falls in the same cycle cmd_done is high.
- Timeout:
  - In REQ, TIMEOUT consecutive cycles without ack abort the command.
  - In RELEASE, TIMEOUT consecutive cycles with ack still high abort the command.
  - Abort: cyc=stb=0 next cycle, cmd_done=cmd_err=1, remaining burst dropped, IDLE.
- Latency, single transfer with a registered-ack slave (cycle 0 = cmd_en high):
  - stb high in cycles 1-2; ack_i high in cycles 2-3.
  - rsp_valid in cycle 3.
  - Next burst stb in cycle 5, or cmd_done in cycle 5.
  - Burst throughput: 4 cycles per word.
- Address wraps 32'hFFFFFFFF→0 without error.
- cmd_en while busy: ignored, no queuing.
- int_pending:
  - Set on a rising edge of wbm_int_i (edge-detect register).
  - Cleared by int_clr.
  - Set and clear in the same cycle: set wins.

Decomposition:
- Shared package wb_master_pkg holds the state enum (IDLE/REQ/RELEASE/FINISH), WB_SEL_ALL=4'hF and WB_DATA_WIDTH=32.
- One sub-module, wbm_timeout_timer: clear input, enable input, expired output at TIMEOUT. It is instantiated once and cleared on every state entry.

Test Plan:
- The bench uses a registered-ack responder matching the slave behaviour above: word 0 = I/O register, word 1 = mask.
- Write 0x5A5A5A5A to adr 1 → stb high in cycles 1-2, we=1, dat_o=0x5A5A5A5A, sel=F; rsp_valid cycle 3 with rsp_dat=0; cmd_done cycle 5, cmd_err=0; responder mask=0x5A5A5A5A.
- Read burst adr 0, count 2, responder words 0x12345678 and 0x5A5A5A5A → rsp_valid pulses 4 cycles apart with those values in order; adr_o 0 then 1; stb never high while ack_i high from the previous word; one cmd_done.
- Read adr 7 with a non-acking responder, TIMEOUT=16 → cyc/stb drop, cmd_done=cmd_err=1 exactly 16 cycles after stb rose; no rsp_valid.
- Read with cmd_count=0 → cmd_done=cmd_err=1 one cycle later, cyc never asserted. cmd_en pulsed mid-burst → ignored, burst completes unchanged.
- Pulse wbm_int_i → int_pending=1 next cycle and stays high; int_clr together with a new rising edge → int_pending stays 1; int_clr alone → 0.
- Assert rst in the cycle after stb rises during a read burst → cyc, stb, busy all 0 next cycle; no done pulse; a fresh command afterwards completes normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone command master: FSM state encoding
// and bus constants.
package wb_master_pkg;
  localparam int         WB_DATA_WIDTH = 32;
  localparam logic [3:0] WB_SEL_ALL    = 4'hF;

  typedef logic [1:0] wbm_state_t;
  localparam wbm_state_t ST_IDLE    = 2'd0;
  localparam wbm_state_t ST_REQ     = 2'd1;
  localparam wbm_state_t ST_RELEASE = 2'd2;
  localparam wbm_state_t ST_FINISH  = 2'd3;
endpackage

// File: rtl/wbm_timeout_timer.sv
// Wait-phase watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th cycle, then holds.
module wbm_timeout_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_reg;

  assign expired = (count_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/wb_cmd_master.sv
// Host-command to Wishbone classic master: single writes, incrementing read
// bursts paced to a registered-ack slave, timeout abort and sticky interrupt.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT     = 256,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_en,
  input  logic                     cmd_wr,
  input  logic [31:0]              cmd_adr,
  input  logic [WB_DATA_WIDTH-1:0] cmd_dat,
  input  logic [COUNT_WIDTH-1:0]   cmd_count,
  output logic                     cmd_busy,
  output logic                     cmd_done,
  output logic                     cmd_err,
  output logic                     rsp_valid,
  output logic [WB_DATA_WIDTH-1:0] rsp_dat,
  output logic                     int_pending,
  input  logic                     int_clr,
  output logic                     wbm_we_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic [3:0]               wbm_sel_o,
  output logic [31:0]              wbm_adr_o,
  output logic [WB_DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [WB_DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                     wbm_ack_i,
  input  logic                     wbm_int_i
);
  wbm_state_t               state_reg, state_next;
  logic [COUNT_WIDTH-1:0]   remaining_reg;
  logic                     busy_reg, done_reg, err_reg, rsp_valid_reg;
  logic [WB_DATA_WIDTH-1:0] rsp_dat_reg, dat_reg;
  logic                     we_reg, cyc_reg, stb_reg;
  logic [3:0]               sel_reg;
  logic [31:0]              adr_reg;
  logic                     int_d_reg, int_pending_reg;
  logic                     accept, start, expired, timer_clr, timer_en;

  // Commands are taken whenever busy is low, which includes the FINISH cycle.
  assign accept    = (state_reg == ST_IDLE || state_reg == ST_FINISH) && cmd_en;
  assign start     = accept && (cmd_wr || cmd_count != '0);
  assign timer_en  = (state_reg == ST_REQ) || (state_reg == ST_RELEASE);
  assign timer_clr = (state_next != state_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_FINISH: state_next = start ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (wbm_ack_i)    state_next = ST_RELEASE;
        else if (expired) state_next = ST_IDLE;
      end
      ST_RELEASE: begin
        if (!wbm_ack_i)   state_next = (remaining_reg != '0) ? ST_REQ : ST_FINISH;
        else if (expired) state_next = ST_IDLE;
      end
      default:            state_next = ST_IDLE;
    endcase
  end

  wbm_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      dat_reg       <= '0;
      we_reg        <= 1'b0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      sel_reg       <= 4'h0;
      adr_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            we_reg        <= cmd_wr;
            adr_reg       <= cmd_adr;
            dat_reg       <= cmd_wr ? cmd_dat : '0;
            remaining_reg <= cmd_wr ? COUNT_WIDTH'(1) : cmd_count;
            cyc_reg       <= 1'b1;
            stb_reg       <= 1'b1;
            sel_reg       <= WB_SEL_ALL;
            busy_reg      <= 1'b1;
          end else if (accept) begin
            done_reg <= 1'b1;
            err_reg  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (wbm_ack_i) begin
            stb_reg       <= 1'b0;
            sel_reg       <= 4'h0;
            rsp_valid_reg <= 1'b1;
            rsp_dat_reg   <= we_reg ? '0 : wbm_dat_i;
            remaining_reg <= remaining_reg - 1'b1;
          end else if (expired) begin
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            sel_reg       <= 4'h0;
            we_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            err_reg       <= 1'b1;
            remaining_reg <= '0;
          end
        end
        ST_RELEASE: begin
          if (!wbm_ack_i) begin
            if (remaining_reg != '0) begin
              adr_reg <= adr_reg + 32'd1;
              stb_reg <= 1'b1;
              sel_reg <= WB_SEL_ALL;
            end else begin
              cyc_reg  <= 1'b0;
              we_reg   <= 1'b0;
              busy_reg <= 1'b0;
              done_reg <= 1'b1;
            end
          end else if (expired) begin
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            err_reg       <= 1'b1;
            remaining_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky interrupt: a new rising edge outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_d_reg       <= 1'b0;
      int_pending_reg <= 1'b0;
    end else begin
      int_d_reg <= wbm_int_i;
      if (wbm_int_i && !int_d_reg) int_pending_reg <= 1'b1;
      else if (int_clr)            int_pending_reg <= 1'b0;
    end
  end

  assign cmd_busy    = busy_reg;
  assign cmd_done    = done_reg;
  assign cmd_err     = err_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_dat     = rsp_dat_reg;
  assign int_pending = int_pending_reg;
  assign wbm_we_o    = we_reg;
  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = stb_reg;
  assign wbm_sel_o   = sel_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
endmodule
